// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared types and constants for the fetch-side PC/branch unit
package pc_branch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
    localparam int          INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pc_target_adder.sv
// rtl/pc_target_adder.sv - branch/jump target adder with word-alignment flag
module pc_target_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_off,
    output logic [XLEN-1:0] o_target,
    output logic            o_aligned
);

    // Plain modular add: wrap-around is the intended behaviour, no carry out.
    assign o_target  = i_base + i_off;
    assign o_aligned = (o_target[1:0] == 2'b00);

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC register, redirect/flush FSM and fetch address generation
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_PC      = TRAP_PC_DEF,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_off,
    input  logic            stall,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);
    localparam logic [2:0]      CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e          r_state;
    logic [2:0]      r_cnt;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_flush;
    logic            r_misalign;

    logic [XLEN-1:0] w_target;
    logic            w_aligned;
    logic            w_taken;

    pc_target_adder #(
        .XLEN (XLEN)
    ) u_target_adder (
        .i_base    (br_pc),
        .i_off     (br_off),
        .o_target  (w_target),
        .o_aligned (w_aligned)
    );

    assign w_taken = br_valid & br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state       <= ST_FETCH;
                    r_fetch_valid <= 1'b1;
                end
                ST_FETCH: begin
                    // A taken branch wins over stall: the redirect must not be lost.
                    if (w_taken) begin
                        r_pc          <= w_aligned ? w_target : TRAP_PC;
                        r_flush       <= 1'b1;
                        r_misalign    <= ~w_aligned;
                        r_cnt         <= CNT_INIT;
                        r_state       <= ST_FLUSH;
                        r_fetch_valid <= 1'b0;
                    end else if (!stall) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path branches are ignored; the bubble count ignores stall.
                    if (r_cnt == 3'd0) begin
                        r_state       <= ST_FETCH;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = r_pc + PC_STEP;
    assign fetch_valid_o = r_fetch_valid;
    assign flush_o       = r_flush;
    assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed and random stimulus against a cycle-level reference model
module tb_pc_branch_unit;

    localparam int          FC      = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_off = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the PC as seen by software, plus how many bubble cycles remain.
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_flush;
    bit          m_mis;
    bit          m_started;
    int          m_bubbles;

    pc_branch_unit #(
        .XLEN         (32),
        .RESET_PC     (RST_PC),
        .TRAP_PC      (TRAP_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_pc         (br_pc),
        .br_off        (br_off),
        .stall         (stall),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_valid   = 1'b0;
        m_flush   = 1'b0;
        m_mis     = 1'b0;
        m_started = 1'b0;
        m_bubbles = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = br_pc + br_off;
        if (!m_started) begin
            m_started = 1'b1;
            m_valid   = 1'b1;
        end else if (m_bubbles > 0) begin
            m_bubbles = m_bubbles - 1;
            m_flush   = 1'b0;
            m_mis     = 1'b0;
            m_valid   = (m_bubbles == 0);
        end else if (br_valid && br_taken) begin
            m_mis     = (tgt % 4) != 0;
            m_pc      = m_mis ? TRAP_PC : tgt;
            m_flush   = 1'b1;
            m_bubbles = FC;
            m_valid   = 1'b0;
        end else begin
            m_flush = 1'b0;
            m_mis   = 1'b0;
            if (!stall) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_outputs();
        chk32("pc", pc_o, m_pc);
        chk32("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk1("fetch_valid", fetch_valid_o, m_valid);
        chk1("flush", flush_o, m_flush);
        chk1("misalign", misalign_o, m_mis);
    endtask

    task automatic step(input bit v, input bit t, input logic [31:0] p, input logic [31:0] o, input bit s);
        br_valid = v;
        br_taken = t;
        br_pc    = p;
        br_off   = o;
        stall    = s;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] p, o;
        model_reset();
        #2;
        check_outputs();
        rst_n = 1'b1;
        #1;
        check_outputs();

        // Sequential fetch, then a 3-cycle stall at 0x8.
        nop(); nop(); nop();
        chk32("seq_pc_8", pc_o, 32'h8);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk32("stall_hold", pc_o, 32'h8);
        nop();
        chk32("stall_resume", pc_o, 32'hC);

        // Aligned taken branch.
        step(1'b1, 1'b1, 32'h20, 32'h10, 1'b0);
        chk32("br_target", pc_o, 32'h30);
        chk1("br_flush", flush_o, 1'b1);
        nop(); nop(); nop();
        chk32("br_next", pc_o, 32'h34);

        // Negative offset with stall, branch during flush ignored, then wrap.
        step(1'b1, 1'b1, 32'h4, 32'hFFFF_FFF8, 1'b1);
        chk32("neg_target", pc_o, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 32'h1000, 32'h40, 1'b0);
        chk32("flush_ignores_br", pc_o, 32'hFFFF_FFFC);
        nop(); nop();
        chk32("wrap", pc_o, 32'h0);

        // Misaligned target traps, then reset lands mid-flush.
        step(1'b1, 1'b1, 32'h40, 32'h6, 1'b0);
        chk32("trap_pc", pc_o, 32'h100);
        chk1("trap_misalign", misalign_o, 1'b1);
        nop();
        async_reset();
        chk32("midflush_reset_pc", pc_o, 32'h0);
        chk1("midflush_reset_flush", flush_o, 1'b0);

        for (int i = 0; i < 600; i++) begin
            p = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 2))
                0:       o = ($urandom & 32'h0000_00FC) - 32'h80;
                1:       o = $urandom & 32'hFFFF_FFFE;
                default: o = $urandom & 32'hFFFF_FFFC;
            endcase
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, p, o, $urandom_range(0, 3) == 0);
            if (i % 150 == 149) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
